// File: rtl/adder_stream_client_if.sv
// ----------------------------------------------------------------------------
// adder_stream_client_if
//
// AXI-Stream link between adder_stream_client (master) and the adder's
// AXI-Stream slave port.
//
// Signals:
//   tvalid  master -> slave  beat valid
//   tready  slave  -> master slave can accept the beat
//   tdata   master -> slave  beat payload, AXIS_MAX_DATAW bits
//   tlast   master -> slave  last beat of the transaction
// ----------------------------------------------------------------------------
interface adder_stream_client_if #(
  parameter int AXIS_MAX_DATAW = 512
);

  logic                      tvalid;
  logic                      tready;
  logic [AXIS_MAX_DATAW-1:0] tdata;
  logic                      tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/adder_stream_client.sv
// ----------------------------------------------------------------------------
// adder_stream_client
//
// Feeds operands to the AXI-Stream adder and collects the sum. Operands come
// in on a valid/ready request port and are buffered in a first-word
// fall-through FIFO of {last, data} entries. They are streamed out as one
// AXI-Stream transaction ending with tlast. The block then waits for the
// adder's response and presents it on the result port for one cycle.
//
// Parameters:
//   DATAW          operand / sum width
//   AXIS_MAX_DATAW AXI-Stream tdata width (>= DATAW), operand zero-extended
//   DEPTH          FIFO entries, power of two, >= 2
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   client_tdata/tlast     operand and its end-of-transaction flag
//   client_valid/ready     request handshake (ready = FIFO not full)
//   axis_client_interface  AXI-Stream master towards the adder
//   response/_valid        adder sum (valid is a level, may stay high)
//   result/result_valid    captured sum, valid pulses for one cycle
//   txn_count              completed transactions, wraps at 2^16
// ----------------------------------------------------------------------------
module adder_stream_client #(
  parameter int DATAW          = 128,
  parameter int AXIS_MAX_DATAW = 512,
  parameter int DEPTH          = 8
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [DATAW-1:0]             client_tdata,
  input  logic                         client_tlast,
  input  logic                         client_valid,
  output logic                         client_ready,

  adder_stream_client_if.master        axis_client_interface,

  input  logic [DATAW-1:0]             response,
  input  logic                         response_valid,

  output logic [DATAW-1:0]             result,
  output logic                         result_valid,
  output logic [15:0]                  txn_count
);

  localparam int PTRW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW   = PTRW + 1;
  localparam int ENTRYW = DATAW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [ENTRYW-1:0] fifo_mem [DEPTH];
  logic [PTRW-1:0]   wr_ptr_reg;
  logic [PTRW-1:0]   wr_ptr_next;
  logic [PTRW-1:0]   rd_ptr_reg;
  logic [PTRW-1:0]   rd_ptr_next;
  logic [CNTW-1:0]   count_reg;
  logic [CNTW-1:0]   count_next;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [ENTRYW-1:0] head_entry;
  logic [DATAW-1:0]  head_data;
  logic              head_last;

  logic              tvalid;
  logic              resp_capture;

  logic [DATAW-1:0]  result_reg;
  logic              result_valid_reg;
  logic [15:0]       txn_count_reg;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == FULL_COUNT);
  assign client_ready = !fifo_full;

  // Full blocks a push even when a pop happens in the same cycle, so ready
  // never depends on tready.
  assign push = client_valid && !fifo_full;
  assign pop  = tvalid && axis_client_interface.tready;

  // Head of the FIFO is read combinationally so the oldest entry is always
  // visible on the stream outputs (first-word fall-through).
  assign head_entry = fifo_mem[rd_ptr_reg];

  // Outputs are forced to zero while the FIFO is empty so stale storage never
  // leaks onto tdata/tlast (the array itself is not cleared on reset).
  assign head_data = fifo_empty ? '0   : head_entry[DATAW-1:0];
  assign head_last = fifo_empty ? 1'b0 : head_entry[DATAW];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {client_tlast, client_tdata};
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTRW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNTW'(1);
      2'b01:   count_next = count_reg - CNTW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        // Draining empty mid-transaction keeps us here; only the beat
        // carrying last ends the transaction.
        if (pop && head_last) begin
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (response_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    tvalid       = 1'b0;
    resp_capture = 1'b0;
    case (state_reg)
      STREAM:    tvalid       = !fifo_empty;
      WAIT_RESP: resp_capture = response_valid;
      default: begin
        tvalid       = 1'b0;
        resp_capture = 1'b0;
      end
    endcase
  end

  assign axis_client_interface.tvalid = tvalid;
  assign axis_client_interface.tdata  = AXIS_MAX_DATAW'(head_data);
  assign axis_client_interface.tlast  = head_last;

  // --------------------------------------------------------------------------
  // Result capture and transaction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      txn_count_reg    <= '0;
    end else begin
      result_valid_reg <= resp_capture;
      if (resp_capture) begin
        result_reg    <= response;
        txn_count_reg <= txn_count_reg + 16'd1;
      end
    end
  end

  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign txn_count    = txn_count_reg;

endmodule
